// File: rtl/mul_seq.sv
// mul_seq: control and capture stage around an external 4-bit shift-add multiplier.
//
// Takes one operand pair over a valid/ready handshake and latches it into the
// operand registers. It then pulses the multiplier load strobe for one cycle and
// counts AW shift-add steps. Next it captures the multiplier's product register,
// and finally holds the product on a valid/ready output handshake until it is
// taken. Only one multiplication is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset (share it with the multiplier)
//   in_valid   operand pair valid
//   in_ready   high only when idle; an operand pair is accepted on valid & ready
//   in_a/in_b  multiplicand / multiplier operand (AW bits)
//   mul_ld     one-cycle load strobe to the multiplier
//   mul_a/b    operand registers, driven to the multiplier at all times
//   mul_rb     multiplier's shifting multiplier register (read for early done)
//   mul_ry     multiplier's product register (2*AW bits)
//   out_valid  product valid; held until out_ready
//   out_ready  downstream accepts the product
//   out_p      registered full-width product
//   busy       high in every state except idle
//
// Build option:
//   MUL_SEQ_EARLY_DONE_EN  when defined, RUN ends as soon as mul_rb is zero.
//                          Any remaining steps could not change mul_ry.
//                          When undefined, RUN always lasts AW edges.

module mul_seq #(
  parameter int unsigned AW = 4,
  parameter int unsigned CW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_a,
  input  logic [AW-1:0]   in_b,
  output logic            mul_ld,
  output logic [AW-1:0]   mul_a,
  output logic [AW-1:0]   mul_b,
  input  logic [AW-1:0]   mul_rb,
  input  logic [2*AW-1:0] mul_ry,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*AW-1:0] out_p,
  output logic            busy
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StRun  = 3'd2,
    StCapt = 3'd3,
    StOut  = 3'd4
  } state_e;

  // Count value present during the final (AW-th) shift-add step.
  localparam logic [CW-1:0] LastStep = CW'(AW - 1);

  state_e          r_state;
  state_e          w_state_next;
  logic [AW-1:0]   r_op_a;
  logic [AW-1:0]   r_op_b;
  logic [CW-1:0]   r_count;
  logic [2*AW-1:0] r_out_p;
  logic            r_out_valid;
  logic            r_mul_ld;
  logic            w_accept;
  logic            w_run_done;

  // Operands can only be taken while idle, so a result transfer and a new
  // accept can never happen on the same edge.
  assign w_accept = in_valid && (r_state == StIdle);

`ifdef MUL_SEQ_EARLY_DONE_EN
  // Once the multiplier register has shifted to zero, every remaining step
  // adds nothing, so the product is already final.
  assign w_run_done = (r_count == LastStep) || (mul_rb == '0);
`else
  logic w_unused_rb;
  assign w_unused_rb = ^mul_rb;
  assign w_run_done  = (r_count == LastStep);
`endif

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = StLoad;
        end
      end
      StLoad: begin
        w_state_next = StRun;
      end
      StRun: begin
        if (w_run_done) begin
          w_state_next = StCapt;
        end
      end
      StCapt: begin
        w_state_next = StOut;
      end
      StOut: begin
        if (out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State, datapath and registered output decodes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_count     <= '0;
      r_out_p     <= '0;
      r_out_valid <= 1'b0;
      r_mul_ld    <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_op_a <= in_a;
        r_op_b <= in_b;
      end

      // The multiplier loads on the edge leaving LOAD, and then takes one step
      // per edge while in RUN.
      if (r_state == StLoad) begin
        r_count <= '0;
      end else if (r_state == StRun) begin
        r_count <= r_count + 1'b1;
      end

      if (r_state == StCapt) begin
        r_out_p <= mul_ry;
      end

      // Decoded from the next state so both strobes come straight off a flop.
      r_out_valid <= (w_state_next == StOut);
      r_mul_ld    <= (w_state_next == StLoad);
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign mul_ld    = r_mul_ld;
  assign mul_a     = r_op_a;
  assign mul_b     = r_op_b;
  assign out_valid = r_out_valid;
  assign out_p     = r_out_p;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq. The bench provides a behavioural shift-add
// multiplier as the DUT's partner. Expected products come from plain a*b.
// Expected latencies come from the step-count rules of the control stage.

module tb_mul_seq;

`ifdef MUL_SEQ_EARLY_DONE_EN
  localparam bit EarlyDone = 1'b1;
`else
  localparam bit EarlyDone = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       mul_ld;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [3:0] mul_rb;
  logic [7:0] mul_ry;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_p;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  mul_seq #(
    .AW(4),
    .CW(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .mul_ld   (mul_ld),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_rb   (mul_rb),
    .mul_ry   (mul_ry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural shift-add multiplier sharing the same reset.
  logic [7:0] m_ra;
  logic [3:0] m_rb;
  logic [7:0] m_ry;
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_ra <= '0;
      m_rb <= '0;
      m_ry <= '0;
    end else if (mul_ld) begin
      m_ra <= {4'b0, mul_a};
      m_rb <= mul_b;
      m_ry <= '0;
    end else begin
      if (m_rb[0]) m_ry <= m_ry + m_ra;
      m_ra <= m_ra << 1;
      m_rb <= m_rb >> 1;
    end
  end
  assign mul_rb = m_rb;
  assign mul_ry = m_ry;

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges from the accept edge to out_valid high. That is accept, load, the RUN
  // edges and capture. An early finish needs one RUN edge past the last set bit.
  function automatic int exp_lat(input logic [3:0] b);
    int steps;
    int run_edges;
    steps = 0;
    for (int k = 0; k < 4; k++) if (b[k]) steps = k + 1;
    run_edges = (EarlyDone && (steps + 1 < 4)) ? steps + 1 : 4;
    return 2 + run_edges;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check({tag, "_ready"}, 32'(in_ready), 1);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int hold,
                        input string tag);
    int edges;
    int exp_p;
    exp_p     = int'(a) * int'(b);
    out_ready = (hold == 0);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    wait_ready(tag);
    step();  // accept edge
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    check({tag, "_ld"}, 32'(mul_ld), 1);
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_mul_a"}, 32'(mul_a), 32'(a));
    check({tag, "_mul_b"}, 32'(mul_b), 32'(b));
    edges = 0;
    while (!out_valid && edges < 50) begin
      step();
      edges++;
      if (edges == 1) check({tag, "_ld_pulse"}, 32'(mul_ld), 0);
    end
    check({tag, "_latency"}, 32'(edges), 32'(exp_lat(b)));
    check({tag, "_p"}, 32'(out_p), 32'(exp_p));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_a     = 4'(h + 1);
      in_b     = 4'(h + 2);
      check({tag, "_hold_valid"}, 32'(out_valid), 1);
      check({tag, "_hold_p"}, 32'(out_p), 32'(exp_p));
      check({tag, "_hold_ready"}, 32'(in_ready), 0);
      step();
    end
    if (hold > 0) begin
      in_valid = 1'b0;
      check({tag, "_ignored_a"}, 32'(mul_a), 32'(a));
      check({tag, "_ignored_b"}, 32'(mul_b), 32'(b));
    end
    out_ready = 1'b1;
    step();  // transfer edge
    check({tag, "_valid_drop"}, 32'(out_valid), 0);
    check({tag, "_idle_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] prev_b;
    int         prev_acc;
    int         n;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_mul_ld", 32'(mul_ld), 0);
    check("rst_out_p", 32'(out_p), 0);
    check("rst_mul_a", 32'(mul_a), 0);
    check("rst_mul_b", 32'(mul_b), 0);

    run_op(4'd13, 4'd11, 0, "op13x11");
    run_op(4'd15, 4'd15, 0, "op15x15");
    run_op(4'd0, 4'd9, 0, "op0x9");
    run_op(4'd7, 4'd6, 5, "bp7x6");
    run_op(4'd5, 4'd0, 0, "b0");
    run_op(4'd9, 4'd1, 0, "b1");
    run_op(4'd11, 4'd8, 0, "b8");
    run_op(4'd10, 4'd2, 0, "b2");

    // Reset during RUN with the step count at 2.
    in_a     = 4'd6;
    in_b     = 4'd7;
    in_valid = 1'b1;
    wait_ready("abort");
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_mul_ld", 32'(mul_ld), 0);
    check("abort_out_p", 32'(out_p), 0);
    for (int i = 0; i < 8; i++) step();
    check("abort_no_result", 32'(out_valid), 0);
    run_op(4'd3, 4'd5, 0, "after_abort");

    // Back-to-back with in_valid and out_ready held high.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prev_acc  = 0;
    prev_b    = '0;
    for (int i = 0; i < 20; i++) begin
      ra   = 4'($urandom_range(15, 0));
      rb   = 4'($urandom_range(15, 0));
      in_a = ra;
      in_b = rb;
      wait_ready("b2b");
      if (i > 0) check("b2b_gap", 32'(cyc + 1 - prev_acc), 32'(exp_lat(prev_b) + 2));
      prev_acc = cyc + 1;
      prev_b   = rb;
      step();  // accept edge
      n = 0;
      while (!out_valid && n < 50) begin
        step();
        n++;
      end
      check("b2b_p", 32'(out_p), int'(ra) * int'(rb));
    end
    in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
